dft64_sample_loader: RTL

// Input stage upstream of the 64-point 8x8 DFT core: accepts one sample per cycle from a valid/ready stream.

---
 rtl/dft64_sample_loader.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/dft64_sample_loader.sv
// dft64_sample_loader: ping-pong frame buffer feeding the 64-point 8x8 DFT core.
// Streams samples in, replays each frame as 8 stride-8 beats, and checks the core's done pulse.
module dft64_sample_loader #(
    parameter int DATA_W    = 16,
    parameter int CALC_HOLD = 12
) (
    input  logic                  clk,
    input  logic                  sreset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_first,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  out_rel,
    output logic [8*DATA_W-1:0]   out_samples,
    output logic                  out_calc,
    input  logic                  dft_done,
    output logic                  busy,
    output logic                  resync_err,
    output logic                  sync_err
);

    localparam int HW = $clog2(CALC_HOLD + 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(CALC_HOLD);

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          r_q, r_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic                load_w;
    logic [2:0]          load_row_w;
    logic                release_w;

    logic [DATA_W-1:0]   mem_q [2][64];
    logic [5:0]          wr_cnt_q, wr_cnt_d;
    logic                wr_bank_q, wr_bank_d;
    logic                rd_bank_q, rd_bank_d;
    logic [1:0]          full_q, full_d;
    logic                accept_w;
    logic                resync_w;
    logic                complete_w;
    logic [5:0]          wr_addr_w;

    logic [8*DATA_W-1:0] samples_q, rd_row_w;
    logic                resync_q, resync_d;
    logic                sync_q, sync_d;
    logic                expect_done_w;

    // Write-side decode: accept, resync drop and frame completion.
    always_comb begin
        accept_w   = in_valid && in_ready;
        resync_w   = accept_w && in_first && (wr_cnt_q != 6'd0);
        complete_w = accept_w && !resync_w && (wr_cnt_q == 6'd63);
        wr_addr_w  = resync_w ? 6'd0 : wr_cnt_q;
    end

    // Next write counter, bank pointers and full flags.
    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;
        resync_d  = resync_q;
        if (accept_w) begin
            if (resync_w) begin
                wr_cnt_d = 6'd1;
                resync_d = 1'b1;
            end else if (complete_w) begin
                wr_cnt_d  = 6'd0;
                wr_bank_d = ~wr_bank_q;
            end else begin
                wr_cnt_d = wr_cnt_q + 6'd1;
            end
        end
        if (complete_w) begin
            full_d[wr_bank_q] = 1'b1;
        end
        if (release_w) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
    end

    // Sample storage; reset only invalidates through the full flags.
    always_ff @(posedge clk) begin
        if (accept_w) begin
            mem_q[wr_bank_q][wr_addr_w] <= in_data;
        end
    end

    // Bank bookkeeping and sticky error registers.
    always_ff @(posedge clk) begin
        if (sreset) begin
            wr_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= '0;
            resync_q  <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
            resync_q  <= resync_d;
            sync_q    <= sync_d;
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (sreset) begin
            state_q <= IDLE;
            r_q     <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            hold_q  <= hold_d;
        end
    end

    // Read FSM next state; row 0 is fetched in the IDLE->EMIT cycle.
    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        hold_d     = hold_q;
        load_w     = 1'b0;
        load_row_w = 3'd0;
        release_w  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d = EMIT;
                    r_d     = 3'd0;
                    load_w  = 1'b1;
                end
            end
            EMIT: begin
                if (r_q == 3'd7) begin
                    state_d = HOLD;
                    hold_d  = HOLD_INIT;
                end else begin
                    r_d        = r_q + 3'd1;
                    load_w     = 1'b1;
                    load_row_w = r_q + 3'd1;
                end
            end
            HOLD: begin
                hold_d = hold_q - 1'b1;
                if (hold_q == HW'(1)) begin
                    state_d   = IDLE;
                    release_w = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read FSM outputs and the expected done slot.
    always_comb begin
        out_rel       = (state_q == EMIT);
        out_calc      = (state_q != IDLE);
        busy          = (state_q != IDLE);
        in_ready      = !sreset && !full_q[wr_bank_q];
        expect_done_w = (state_q == HOLD) && (hold_q == HOLD_INIT);
        sync_d        = sync_q || (dft_done != expect_done_w);
        resync_err    = resync_q;
        sync_err      = sync_q;
        out_samples   = samples_q;
    end

    // Stride-8 gather of one row: column c reads address 8c+r.
    always_comb begin
        rd_row_w = '0;
        for (int c = 0; c < 8; c++) begin
            rd_row_w[c*DATA_W +: DATA_W] = mem_q[rd_bank_q][{3'(c), load_row_w}];
        end
    end

    // Beat register, held between beats.
    always_ff @(posedge clk) begin
        if (sreset) begin
            samples_q <= '0;
        end else if (load_w) begin
            samples_q <= rd_row_w;
        end
    end

endmodule
